multu_unit: RTL and testbench
=============================

MULTU_UNIT -- requirements
Module: multu_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; HI and LO are each WIDTH bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 funct  input  6  operation select: MULTU 6'b011001, MFHI 6'b010000, MFLO 6'b010010.
REQ-006 a  input  WIDTH  multiplicand, captured on accepted start.
REQ-007 b  input  WIDTH  multiplier, captured on accepted start.
REQ-008 dataOut  output  WIDTH  HI when funct=MFHI, LO when funct=MFLO, else 0; combinational from committed registers.
REQ-009 busy  output  1  high while a multiply is in progress (RUN state).
REQ-010 done  output  1  single-cycle pulse when HI/LO are committed.

Function
REQ-011 FSM states: IDLE, RUN, DONE; the FSM shall occupy exactly one state at a time.
REQ-012 IDLE->RUN when start=1 and funct=MULTU; shall load mcand<=a, prod<={WIDTH'b0,b}, count<=0.
REQ-013 start with any other funct in IDLE shall be ignored; FSM stays IDLE.
REQ-014 RUN, each cycle: if prod[0]=1, upper half plus mcand computed at WIDTH+1 bits (carry kept), else upper half plus 0; the full {carry,upper,lower} shifts right one bit into prod; count increments.
REQ-015 RUN->DONE when count reaches WIDTH-1 on the current step, i.e. after exactly WIDTH shift-add steps.
REQ-016 DONE: HI<=prod[2*WIDTH-1:WIDTH], LO<=prod[WIDTH-1:0]; done=1 for that cycle only; DONE->IDLE unconditionally.
REQ-017 Latency: start accepted at edge N, done high during cycle after edge N+WIDTH+1 (33 cycles for WIDTH=32); a new start is accepted the cycle after done.
REQ-018 start asserted in RUN or DONE shall be ignored and not queued.
REQ-019 HI/LO shall hold previous committed values throughout RUN; MFHI/MFLO during busy return old values.
REQ-020 Product is unsigned and exact: 2*WIDTH bits, no overflow; all-ones x all-ones = {WIDTH-1 ones, 0, WIDTH-1 zeros, 1}.
REQ-021 Operand change on a/b after start is accepted shall not affect the result.

Reset
REQ-022 rst=1 shall immediately force state=IDLE, HI=0, LO=0, mcand=0, prod=0, count=0, busy=0, done=0.
REQ-023 rst asserted mid-RUN shall abort the multiply; no HI/LO commit, no done pulse.
REQ-024 First start after rst deassertion shall be accepted on the first rising edge with rst low.

Configuration
REQ-025 Macro MULT_SIGNED_EN: when defined, funct 6'b011000 (MULT) shall also be accepted; operands are converted to magnitudes at capture, sign = a[WIDTH-1]^b[WIDTH-1] stored, and the 2*WIDTH product two's-complement negated in DONE before commit if sign=1; latency unchanged.
REQ-026 Without MULT_SIGNED_EN: funct 6'b011000 shall be treated as unrecognised (ignored in IDLE, dataOut=0).

Structure
REQ-027 Shared package mult_pkg shall hold the funct constants (MULTU, MULT, MFHI, MFLO), the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and the default WIDTH.
REQ-028 One sub-module, mult_adder: WIDTH-bit ripple adder producing WIDTH-bit sum plus carry-out, built from the existing full-adder cell; multu_unit instantiates it once.

Verification
REQ-029 rst mid-RUN at step 10 after start with a=7,b=9 -> busy=0 next edge, no done pulse, MFLO=0, MFHI=0.
REQ-030 start, MULTU, a=6, b=7 -> done exactly 33 cycles later; MFLO=42, MFHI=0.
REQ-031 a=32'hFFFFFFFF, b=32'hFFFFFFFF -> MFHI=32'hFFFFFFFE, MFLO=32'h00000001.
REQ-032 Second start pulsed at cycle 5 of RUN with a=1,b=1 -> ignored; first result unchanged; MFLO read during RUN returns prior value.
REQ-033 start with funct=MFHI in IDLE -> busy stays 0, no done, dataOut=HI.
REQ-034 MULT_SIGNED_EN defined, MULT a=-3 (32'hFFFFFFFD), b=5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; undefined -> ignored.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - funct codes, FSM state encoding and default width for multu_unit
package mult_pkg;

    localparam int MULT_DEFAULT_WIDTH = 32;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full-adder cell
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/mult_adder.sv
// rtl/mult_adder.sv - WIDTH-bit ripple-carry adder built from full_adder cells
module mult_adder
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            full_adder u_fa (
                .i_a    (i_a[gi]),
                .i_b    (i_b[gi]),
                .i_cin  (w_carry[gi]),
                .o_sum  (o_sum[gi]),
                .o_cout (w_carry[gi+1])
            );
        end
    endgenerate

    assign o_cout = w_carry[WIDTH];

endmodule

// File: rtl/multu_unit.sv
// rtl/multu_unit.sv - shift-add HI/LO multiplier, one bit per cycle; MULT_SIGNED_EN adds signed MULT
module multu_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_is_mul;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic [2*WIDTH-1:0] w_result;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

`ifdef MULT_SIGNED_EN
    logic r_sign;
    logic w_signed_op;

    // Signed MULT runs the same unsigned datapath on magnitudes; the sign is reapplied at commit.
    assign w_signed_op = (funct == FUNCT_MULT);
    assign w_is_mul    = (funct == FUNCT_MULTU) || w_signed_op;
    assign w_op_a      = (w_signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_op_b      = (w_signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign w_result    = r_sign ? (~r_prod + {{(2*WIDTH-1){1'b0}}, 1'b1}) : r_prod;
`else
    assign w_is_mul    = (funct == FUNCT_MULTU);
    assign w_op_a      = a;
    assign w_op_b      = b;
    assign w_result    = r_prod;
`endif

    assign w_addend = r_prod[0] ? r_mcand : {WIDTH{1'b0}};

    mult_adder #(.WIDTH(WIDTH)) u_adder (
        .i_a    (r_prod[2*WIDTH-1:WIDTH]),
        .i_b    (w_addend),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mcand <= '0;
            r_prod  <= '0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef MULT_SIGNED_EN
            r_sign  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && w_is_mul) begin
                        r_mcand <= w_op_a;
                        r_prod  <= {{WIDTH{1'b0}}, w_op_b};
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
`ifdef MULT_SIGNED_EN
                        r_sign  <= w_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
                    end
                end
                ST_RUN: begin
                    // Carry out of the upper-half add becomes the new MSB after the shift.
                    r_prod  <= {w_cout, w_sum, r_prod[WIDTH-1:1]};
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_hi    <= w_result[2*WIDTH-1:WIDTH];
                    r_lo    <= w_result[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dataOut = '0;
        if (funct == FUNCT_MFHI) begin
            dataOut = r_hi;
        end else if (funct == FUNCT_MFLO) begin
            dataOut = r_lo;
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_multu_unit.sv
// tb/tb_multu_unit.sv - directed scoreboard bench for multu_unit
module tb_multu_unit;
    import mult_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [5:0]     funct;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   dataOut;
    logic           busy;
    logic           done;

    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    multu_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct   (funct),
        .a       (a),
        .b       (b),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hl(output logic [2*W-1:0] hl);
        logic [5:0] saved;
        saved = funct;
        funct = FUNCT_MFHI;
        #1 hl[2*W-1:W] = dataOut;
        funct = FUNCT_MFLO;
        #1 hl[W-1:0] = dataOut;
        funct = saved;
    endtask

    task automatic launch(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        start = 1'b1;
        funct = f;
        a     = x;
        b     = y;
        if (push) exp_q.push_back({{W{1'b0}}, x} * {{W{1'b0}}, y});
        step();
        start = 1'b0;
        funct = 6'd0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        logic [2*W-1:0] hl;
        logic [2*W-1:0] exp;
        n = 0;
        while (!done && n < 80) begin
            step();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : {2*W{1'bx}};
        read_hl(hl);
        check({tag, " HI:LO"}, hl, exp);
        step();
        check({tag, " done single pulse"}, 64'(done), 64'(0));
    endtask

    task automatic no_done_window(input string tag, input int n);
        int c;
        c = 0;
        repeat (n) begin
            step();
            if (done) c++;
        end
        check({tag, " no done"}, 64'(c), 64'(0));
    endtask

    initial begin
        logic [2*W-1:0] hl;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;

        rst   = 1'b1;
        start = 1'b0;
        funct = 6'd0;
        a     = '0;
        b     = '0;
        repeat (3) step();
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        read_hl(hl);
        check("reset HI:LO", hl, 64'(0));
        rst = 1'b0;

        // first start right after reset release, then busy during RUN
        launch(FUNCT_MULTU, 32'd6, 32'd7, 1'b1);
        check("busy after accept", 64'(busy), 64'(1));
        wait_done("6x7", W + 1);

        launch(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_done("ones x ones", W + 1);

        // non-multiply funct with start in IDLE
        start = 1'b1;
        funct = FUNCT_MFHI;
        step();
        start = 1'b0;
        check("MFHI start busy", 64'(busy), 64'(0));
        #1 check("MFHI dataOut", 64'(dataOut), 64'(32'hFFFFFFFE));
        no_done_window("MFHI start", 40);
        funct = 6'd0;
        #1 check("unknown funct dataOut", 64'(dataOut), 64'(0));

        // start pulsed during RUN must be dropped; old LO visible meanwhile
        launch(FUNCT_MULTU, 32'd100, 32'd3, 1'b1);
        repeat (4) step();
        funct = FUNCT_MFLO;
        #1 check("MFLO during RUN", 64'(dataOut), 64'(1));
        start = 1'b1;
        funct = FUNCT_MULTU;
        a     = 32'd1;
        b     = 32'd1;
        step();
        start = 1'b0;
        funct = 6'd0;
        wait_done("100x3 with ignored start", W + 1 - 5);
        no_done_window("ignored start not queued", 40);

`ifdef MULT_SIGNED_EN
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
        launch(FUNCT_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
        wait_done("MULT -3x5", W + 1);
`else
        launch(FUNCT_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
        check("MULT ignored busy", 64'(busy), 64'(0));
        funct = FUNCT_MULT;
        #1 check("MULT funct dataOut", 64'(dataOut), 64'(0));
        funct = 6'd0;
        no_done_window("MULT ignored", 40);
        read_hl(hl);
        check("MULT ignored HI:LO", hl, 64'(300));
`endif

        // reset after ten shift-add steps aborts the multiply
        launch(FUNCT_MULTU, 32'd7, 32'd9, 1'b0);
        repeat (10) step();
        check("busy before abort", 64'(busy), 64'(1));
        rst = 1'b1;
        #1 check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        read_hl(hl);
        check("abort HI:LO", hl, 64'(0));
        step();
        rst = 1'b0;
        check("abort busy after edge", 64'(busy), 64'(0));
        no_done_window("aborted run", 40);
        read_hl(hl);
        check("abort HI:LO held", hl, 64'(0));

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            launch(FUNCT_MULTU, ra, rb, 1'b1);
            wait_done($sformatf("random %0d", i), W + 1);
        end

        check("scoreboard drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
